ks_note_sequencer: RTL and testbench
====================================

KS_NOTE_SEQUENCER -- requirements
Module: ks_note_sequencer

Interface
REQ-001 Parameters (name, default, meaning): NUM_STEPS, 8, pattern depth; DATA_WIDTH, 8, period/gate width; TEMPO_WIDTH, 16, step-length counter width.
REQ-002 clk  in  1  system clock.
REQ-003 rst_n  in  1  synchronous, active-low reset.
REQ-004 sample_tick_i  in  1  one-clk strobe at the KS sample rate; all timing counts these ticks.
REQ-005 wr_en_i  in  1  pattern write strobe.
REQ-006 wr_addr_i  in  3  pattern slot address.
REQ-007 wr_data_i  in  DATA_WIDTH  period for the slot; 0 means rest.
REQ-008 tempo_i  in  TEMPO_WIDTH  step length in sample ticks.
REQ-009 gate_len_i  in  DATA_WIDTH  pluck-high length in sample ticks.
REQ-010 num_steps_i  in  4  active pattern length.
REQ-011 run_i  in  1  level; start/continue the sequence.
REQ-012 single_shot_i  in  1  1: stop after the last step; 0: loop.
REQ-013 period_o  out  DATA_WIDTH  period to the string datapath.
REQ-014 pluck_o  out  1  pluck level to the string datapath.
REQ-015 step_o  out  3  index of the current step.
REQ-016 busy_o  out  1  high when not in IDLE.
REQ-017 done_o  out  1  one-clk pulse on sequence end.

Function
REQ-018 Storage: NUM_STEPS x DATA_WIDTH register array, written on wr_en_i in any state.
REQ-019 FSM states: IDLE, START, PLAY.
REQ-020 IDLE->START: run_i=1 sampled on any clk.
REQ-021 START, one clk:
- latch period_o = slot[step].
- latch the tempo, gate and length inputs.
- clear the tick counter.
- go to PLAY.
REQ-022 Write-first: if the written slot is the slot being latched in START in the same clk, wr_data_i is latched.
REQ-023 Effective values are computed in START:
- T = max(tempo_i, 1).
- G = min(gate_len_i, T-1).
- N = clamp(num_steps_i, 1, NUM_STEPS).
REQ-024 PLAY:
- pluck_o = 1 while tick count < G and the latched period != 0.
- pluck_o goes high the clk after START.
- The tick counter increments on each sample_tick_i.
REQ-025 Step boundary: the sample_tick_i on which the count reaches T-1.
REQ-026 At a boundary with step < N-1 and run_i=1: step increments, then START.
REQ-027 At a boundary on the last step (step = N-1):
- single_shot_i=0 and run_i=1: step wraps to 0, then START.
- single_shot_i=1: step -> 0, IDLE, done_o pulse.
REQ-028 run_i=0 at any boundary: IDLE, step_o -> 0, done_o pulse.
REQ-029 run_i deassert mid-step:
- The current step completes, gate included.
- No abort, except by reset.
REQ-030 Rest slots (period 0):
- pluck_o stays 0.
- period_o holds the previous non-zero period.
- Step timing is unchanged.
REQ-031 G=0 (gate 0 or T=1): pluck_o is never asserted; steps still advance.
REQ-032 pluck_o is always low for at least one sample tick before each step boundary when T>=2, so each non-rest step re-plucks.
REQ-033 Input changes mid-step: tempo_i, gate_len_i and num_steps_i changes take effect at the next START only.
REQ-034 Outputs are registered: no combinational path from inputs to outputs.
REQ-035 done_o and the START transition never coincide with a pluck_o rising edge.

Reset
REQ-036 On rst_n=0 at clk:
- FSM -> IDLE.
- step_o, tick counter, period_o, pluck_o, done_o, busy_o -> 0.
- All pattern slots -> 0.
REQ-037 Reset mid-PLAY:
- pluck_o drops on that clk.
- No done_o pulse.
- Pattern contents are lost.

Structure
REQ-038 Shared package ks_pkg holds:
- FSM state enum.
- NUM_STEPS, KS_DATA_WIDTH and TEMPO_WIDTH constants.
- The clamp/min helper functions.
REQ-039 One sub-module, ks_seq_timer: the tick counter with the boundary and gate compares.
REQ-040 The pattern array stays in the top module.

Verification
REQ-041 Loop/rest/advance: slots {20,0,30}, N=3, T=4, G=2, loop, run=1 -> periods 20,20,30,20 each for 4 ticks; pluck_o high 2 ticks on steps 0 and 2; step 1 silent.
REQ-042 Single-shot: N=2, T=3, single_shot=1 -> done_o pulses once, 6 ticks after start; busy_o=0 the next clk; step_o=0.
REQ-043 Gate clamp: G=10, T=5 -> pluck_o high exactly 4 ticks per step; tempo_i=0 -> step every tick, pluck_o never high.
REQ-044 Write-first: write slot1=55 in the same clk as START of step 1 -> period_o=55.
REQ-045 Stop/reset: run_i dropped at tick 1 of step 0 (T=8) -> IDLE after tick 7 with done_o. rst_n low mid-gate -> pluck_o=0 next clk, done_o stays 0.
REQ-046 Clamp: num_steps_i=0 -> single step repeats; num_steps_i=12 -> wraps after step 7.

Source files
------------

// File: rtl/ks_pkg.sv
// Shared definitions for the Karplus-Strong note sequencer: FSM states,
// default sizes and small integer helpers used to sanitise control inputs.
package ks_pkg;

  localparam int NUM_STEPS     = 8;
  localparam int KS_DATA_WIDTH = 8;
  localparam int TEMPO_WIDTH   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_PLAY  = 2'd2
  } ks_state_e;

  function automatic int unsigned ks_min(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  function automatic int unsigned ks_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned ks_clamp(input int unsigned v, input int unsigned lo,
                                           input int unsigned hi);
    return ks_min(ks_max(v, lo), hi);
  endfunction

endpackage

// File: rtl/ks_seq_timer.sv
// Step timer: counts sample ticks within one step, flags the tick that ends
// the step and predicts whether the pluck gate is open after this clock.
module ks_seq_timer #(
  parameter int TEMPO_WIDTH = 16,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_i,
  input  logic                   en_i,
  input  logic                   tick_i,
  input  logic [TEMPO_WIDTH-1:0] tempo_i,
  input  logic [DATA_WIDTH-1:0]  gate_i,
  output logic                   boundary_o,
  output logic                   gate_next_o
);

  logic [TEMPO_WIDTH-1:0] count_q;
  logic [TEMPO_WIDTH-1:0] count_next;
  logic [TEMPO_WIDTH-1:0] tempo_q;
  logic [DATA_WIDTH-1:0]  gate_q;

  // Next count, end-of-step detection and gate prediction; a load restarts the step at count 0.
  always_comb begin
    boundary_o = en_i && tick_i && (count_q == tempo_q - TEMPO_WIDTH'(1));
    count_next = count_q;
    if (load_i || boundary_o) begin
      count_next = '0;
    end else if (en_i && tick_i) begin
      count_next = count_q + TEMPO_WIDTH'(1);
    end
    if (load_i) begin
      gate_next_o = (gate_i != '0);
    end else begin
      gate_next_o = en_i && !boundary_o && (32'(count_next) < 32'(gate_q));
    end
  end

  // Tick counter plus the step length and gate captured when a step starts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      tempo_q <= '0;
      gate_q  <= '0;
    end else begin
      count_q <= count_next;
      if (load_i) begin
        tempo_q <= tempo_i;
        gate_q  <= gate_i;
      end
    end
  end

endmodule

// File: rtl/ks_note_sequencer.sv
// Pattern sequencer feeding a Karplus-Strong string: plays a programmable
// list of periods, one per step, with a pluck pulse at the start of each step.
module ks_note_sequencer #(
  parameter int NUM_STEPS   = ks_pkg::NUM_STEPS,
  parameter int DATA_WIDTH  = ks_pkg::KS_DATA_WIDTH,
  parameter int TEMPO_WIDTH = ks_pkg::TEMPO_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sample_tick_i,
  input  logic                   wr_en_i,
  input  logic [2:0]             wr_addr_i,
  input  logic [DATA_WIDTH-1:0]  wr_data_i,
  input  logic [TEMPO_WIDTH-1:0] tempo_i,
  input  logic [DATA_WIDTH-1:0]  gate_len_i,
  input  logic [3:0]             num_steps_i,
  input  logic                   run_i,
  input  logic                   single_shot_i,
  output logic [DATA_WIDTH-1:0]  period_o,
  output logic                   pluck_o,
  output logic [2:0]             step_o,
  output logic                   busy_o,
  output logic                   done_o
);
  import ks_pkg::*;

  ks_state_e              state_q, state_d;
  logic [DATA_WIDTH-1:0]  slot_q [NUM_STEPS];
  logic [DATA_WIDTH-1:0]  slot_rd, period_sel, period_q;
  logic [DATA_WIDTH-1:0]  gate_eff;
  logic [TEMPO_WIDTH-1:0] tempo_eff;
  logic [3:0]             steps_eff, steps_q;
  logic [2:0]             step_q, step_d;
  logic                   period_nz_q, pluck_q, done_q, done_d, busy_q;
  logic                   load, boundary, gate_next;

  // Pattern memory; writable in every state, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STEPS; i++) slot_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        if (wr_en_i && wr_addr_i == 3'(i)) slot_q[i] <= wr_data_i;
      end
    end
  end

  // Current slot read with write bypass, and sanitised tempo/gate/length for the next step.
  always_comb begin
    slot_rd = '0;
    for (int i = 0; i < NUM_STEPS; i++) begin
      if (step_q == 3'(i)) slot_rd = slot_q[i];
    end
    period_sel = (wr_en_i && wr_addr_i == step_q) ? wr_data_i : slot_rd;
    tempo_eff  = TEMPO_WIDTH'(ks_max(32'(tempo_i), 32'd1));
    gate_eff   = DATA_WIDTH'(ks_min(32'(gate_len_i), 32'(tempo_eff) - 32'd1));
    steps_eff  = 4'(ks_clamp(32'(num_steps_i), 32'd1, 32'(NUM_STEPS)));
  end

  // Next-state logic: run gating, step advance, wrap and end-of-sequence decisions.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run_i) state_d = ST_START;
      end
      ST_START: begin
        load    = 1'b1;
        state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (boundary) begin
          if (!run_i) begin
            state_d = ST_IDLE;
            step_d  = '0;
            done_d  = 1'b1;
          end else if ({1'b0, step_q} != steps_q - 4'd1) begin
            state_d = ST_START;
            step_d  = step_q + 3'd1;
          end else if (single_shot_i) begin
            state_d = ST_IDLE;
            step_d  = '0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_START;
            step_d  = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        step_d  = '0;
      end
    endcase
  end

  // State and step index registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // Registered outputs; rest slots keep the last real period but never pluck.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_q    <= '0;
      period_nz_q <= 1'b0;
      steps_q     <= '0;
      pluck_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      done_q  <= done_d;
      busy_q  <= (state_d != ST_IDLE);
      pluck_q <= gate_next && (load ? (period_sel != '0) : period_nz_q);
      if (load) begin
        steps_q     <= steps_eff;
        period_nz_q <= (period_sel != '0);
        if (period_sel != '0) period_q <= period_sel;
      end
    end
  end

  ks_seq_timer #(
    .TEMPO_WIDTH(TEMPO_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .en_i       (state_q == ST_PLAY),
    .tick_i     (sample_tick_i),
    .tempo_i    (tempo_eff),
    .gate_i     (gate_eff),
    .boundary_o (boundary),
    .gate_next_o(gate_next)
  );

  assign period_o = period_q;
  assign pluck_o  = pluck_q;
  assign step_o   = step_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_ks_note_sequencer.sv
// Scoreboard bench for ks_note_sequencer: each sample tick while busy is
// compared against a queued (step, period, pluck) record, and each done
// pulse against the queued number of ticks the sequence should have taken.
module tb_ks_note_sequencer;

  localparam int DW = 8;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_tick_i = 1'b0;
  logic          wr_en_i = 1'b0;
  logic [2:0]    wr_addr_i = '0;
  logic [DW-1:0] wr_data_i = '0;
  logic [TW-1:0] tempo_i = '0;
  logic [DW-1:0] gate_len_i = '0;
  logic [3:0]    num_steps_i = '0;
  logic          run_i = 1'b0;
  logic          single_shot_i = 1'b0;
  logic [DW-1:0] period_o;
  logic          pluck_o;
  logic [2:0]    step_o;
  logic          busy_o;
  logic          done_o;

  typedef struct {
    int step;
    int period;
    int pluck;
  } rec_t;

  rec_t expQ[$];
  int   doneQ[$];
  int   errors = 0;
  int   checks = 0;
  int   ticksSinceDone = 0;

  ks_note_sequencer #(.NUM_STEPS(8), .DATA_WIDTH(DW), .TEMPO_WIDTH(TW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_tick_i(sample_tick_i),
    .wr_en_i      (wr_en_i),
    .wr_addr_i    (wr_addr_i),
    .wr_data_i    (wr_data_i),
    .tempo_i      (tempo_i),
    .gate_len_i   (gate_len_i),
    .num_steps_i  (num_steps_i),
    .run_i        (run_i),
    .single_shot_i(single_shot_i),
    .period_o     (period_o),
    .pluck_o      (pluck_o),
    .step_o       (step_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  initial forever #5 clk = ~clk;

  // Sample tick: one clock high out of every four.
  initial begin : tickGen
    int phase;
    phase = 0;
    forever begin
      @(posedge clk);
      #1;
      phase = (phase + 1) % 4;
      sample_tick_i = (phase == 0);
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic reportUnexpected(input string name, input int actual);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got %0d with nothing expected", name, actual);
  endtask

  task automatic applyStimulus(input int tempo, input int gate, input int nsteps, input int single);
    tempo_i       = TW'(tempo);
    gate_len_i    = DW'(gate);
    num_steps_i   = 4'(nsteps);
    single_shot_i = (single != 0);
  endtask

  task automatic pushStep(input int step, input int period, input int ticks, input int high);
    for (int k = 0; k < ticks; k++) expQ.push_back('{step, period, (k < high) ? 1 : 0});
  endtask

  task automatic writeSlot(input int addr, input int data);
    @(posedge clk);
    #1;
    wr_en_i   = 1'b1;
    wr_addr_i = 3'(addr);
    wr_data_i = DW'(data);
    @(posedge clk);
    #1;
    wr_en_i   = 1'b0;
  endtask

  task automatic waitTicks(input int n);
    repeat (n) @(posedge clk iff sample_tick_i);
    #1;
  endtask

  task automatic startRun();
    waitTicks(1);
    run_i = 1'b1;
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (busy_o && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy_o) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: busy_o still %0d after %0d cycles, expected 0", name, busy_o, n);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every busy sample tick and every done pulse against the queues.
  initial begin : monitor
    rec_t r;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ticksSinceDone = 0;
      end else begin
        if (busy_o && sample_tick_i) begin
          if (expQ.size() == 0) begin
            reportUnexpected("extra step tick, step_o", int'(step_o));
          end else begin
            r = expQ.pop_front();
            checkOutput("step_o", int'(step_o), r.step);
            checkOutput("period_o", int'(period_o), r.period);
            checkOutput("pluck_o", int'(pluck_o), r.pluck);
          end
          ticksSinceDone++;
        end
        if (done_o) begin
          if (doneQ.size() == 0) begin
            reportUnexpected("extra done_o, ticks", ticksSinceDone);
          end else begin
            checkOutput("ticks to done_o", ticksSinceDone, doneQ.pop_front());
            checkOutput("busy_o at done", int'(busy_o), 0);
            checkOutput("step_o at done", int'(step_o), 0);
            checkOutput("pluck_o at done", int'(pluck_o), 0);
          end
          ticksSinceDone = 0;
        end
      end
    end
  end

  initial begin : stimulus
    int per[8];
    per = '{20, 55, 30, 60, 61, 62, 63, 64};

    $display("[TB] reset");
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset period_o", int'(period_o), 0);
    checkOutput("reset pluck_o", int'(pluck_o), 0);
    checkOutput("reset step_o", int'(step_o), 0);
    checkOutput("reset busy_o", int'(busy_o), 0);
    checkOutput("reset done_o", int'(done_o), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] loop with rest step");
    writeSlot(0, 20);
    writeSlot(1, 0);
    writeSlot(2, 30);
    applyStimulus(4, 2, 3, 0);
    pushStep(0, 20, 4, 2);
    pushStep(1, 20, 4, 0);
    pushStep(2, 30, 4, 2);
    pushStep(0, 20, 4, 2);
    doneQ.push_back(16);
    startRun();
    waitTicks(13);
    run_i = 1'b0;
    waitIdle("loop idle");

    $display("[TB] single shot");
    writeSlot(1, 40);
    applyStimulus(3, 1, 2, 1);
    pushStep(0, 20, 3, 1);
    pushStep(1, 40, 3, 1);
    doneQ.push_back(6);
    startRun();
    waitTicks(6);
    run_i = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("busy_o after single shot", int'(busy_o), 0);
    checkOutput("step_o after single shot", int'(step_o), 0);
    waitIdle("single shot idle");
    single_shot_i = 1'b0;

    $display("[TB] gate clamp with zero step count");
    applyStimulus(5, 10, 0, 0);
    pushStep(0, 20, 5, 4);
    pushStep(0, 20, 5, 4);
    doneQ.push_back(10);
    startRun();
    waitTicks(6);
    run_i = 1'b0;
    waitIdle("gate clamp idle");

    $display("[TB] zero tempo");
    applyStimulus(0, 3, 2, 0);
    pushStep(0, 20, 1, 0);
    pushStep(1, 40, 1, 0);
    pushStep(0, 20, 1, 0);
    pushStep(1, 40, 1, 0);
    doneQ.push_back(4);
    startRun();
    waitTicks(3);
    run_i = 1'b0;
    waitIdle("zero tempo idle");

    $display("[TB] write-first into starting step");
    applyStimulus(2, 1, 2, 0);
    pushStep(0, 20, 2, 1);
    pushStep(1, 55, 2, 1);
    doneQ.push_back(4);
    startRun();
    waitTicks(2);
    wr_en_i   = 1'b1;
    wr_addr_i = 3'd1;
    wr_data_i = 8'd55;
    run_i     = 1'b0;
    @(posedge clk);
    #1;
    wr_en_i   = 1'b0;
    waitIdle("write-first idle");

    $display("[TB] run dropped early in a long step");
    applyStimulus(8, 3, 3, 0);
    pushStep(0, 20, 8, 3);
    doneQ.push_back(8);
    startRun();
    waitTicks(1);
    run_i = 1'b0;
    waitIdle("stop idle");

    $display("[TB] step count above depth");
    for (int i = 3; i < 8; i++) writeSlot(i, per[i]);
    applyStimulus(1, 5, 12, 0);
    for (int i = 0; i < 8; i++) pushStep(i, per[i], 1, 0);
    pushStep(0, 20, 1, 0);
    pushStep(1, 55, 1, 0);
    doneQ.push_back(10);
    startRun();
    waitTicks(9);
    run_i = 1'b0;
    waitIdle("depth clamp idle");

    $display("[TB] reset during gate");
    applyStimulus(8, 4, 1, 0);
    pushStep(0, 20, 1, 1);
    startRun();
    waitTicks(1);
    rst_n = 1'b0;
    run_i = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("pluck_o after mid-gate reset", int'(pluck_o), 0);
    checkOutput("done_o after mid-gate reset", int'(done_o), 0);
    checkOutput("busy_o after mid-gate reset", int'(busy_o), 0);
    checkOutput("period_o after mid-gate reset", int'(period_o), 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("done_o held in reset", int'(done_o), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(2, 1, 1, 0);
    pushStep(0, 0, 2, 0);
    doneQ.push_back(2);
    startRun();
    waitTicks(1);
    run_i = 1'b0;
    waitIdle("post-reset idle");

    checkOutput("leftover step records", expQ.size(), 0);
    checkOutput("leftover done pulses", doneQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
